instr_fetch_mem: RTL

Parametrised, byte-addressed instruction memory with a registered fetch handshake. It replaces the CPU's zero-state, fixed-delay fetch path. It adds:
- a configurable fetch latency, with a BUSY stall output to the CPU;
- alignment and range checking of the fetch address;
- a synchronous program-load port, so benches and boot logic can write words without poking arrays.

It sits between the CPU's PC/INSTRUCTION interface and the program image.

---
 rtl/instr_fetch_mem.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/instr_fetch_mem.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_mem
// Purpose  : Byte-addressed instruction memory with a registered, fixed-
//            latency fetch handshake, address checking and a synchronous
//            word-load port.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   CLK          in   1            system clock, rising edge
//   RESET        in   1            synchronous active-high reset
//   PC           in   32           fetch byte address
//   FETCH_REQ    in   1            fetch request (accepted while BUSY=0)
//   INSTRUCTION  out  8*WORD_BYTES fetched word, held between fetches
//   INSTR_VALID  out  1            one-cycle pulse, INSTRUCTION is new
//   BUSY         out  1            fetch in flight, CPU must stall
//   FETCH_ERR    out  1            one-cycle pulse, bad fetch address
//   LOAD_EN      in   1            write one word
//   LOAD_ADDR    in   ADDR_BITS    byte address of write (low bits ignored)
//   LOAD_DATA    in   8*WORD_BYTES word to write, byte 0 at lowest address
// ============================================================================
module instr_fetch_mem #(
  parameter int ADDR_BITS  = 10,
  parameter int WORD_BYTES = 4,
  parameter int LATENCY    = 2
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [31:0]             PC,
  input  logic                    FETCH_REQ,
  output logic [8*WORD_BYTES-1:0] INSTRUCTION,
  output logic                    INSTR_VALID,
  output logic                    BUSY,
  output logic                    FETCH_ERR,
  input  logic                    LOAD_EN,
  input  logic [ADDR_BITS-1:0]    LOAD_ADDR,
  input  logic [8*WORD_BYTES-1:0] LOAD_DATA
);

  localparam int                   c_DATA_BITS  = 8 * WORD_BYTES;
  localparam int                   c_MEM_BYTES  = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] c_ALIGN_MASK = ADDR_BITS'(WORD_BYTES - 1);
  localparam logic [3:0]           c_CNT_LOAD   = 4'(LATENCY - 1);

  generate
    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $fatal(1, "instr_fetch_mem: LATENCY must be in 1..15");
    end
    if ((WORD_BYTES < 1) || ((WORD_BYTES & (WORD_BYTES - 1)) != 0)) begin : g_bad_word_bytes
      $fatal(1, "instr_fetch_mem: WORD_BYTES must be a power of two");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [3:0]             r_cnt;
  logic [3:0]             w_cnt_nxt;
  logic [ADDR_BITS-1:0]   r_addr;
  logic [c_DATA_BITS-1:0] r_instr;
  logic                   r_err;
  logic [7:0]             r_mem [c_MEM_BYTES];

  logic                   w_pc_ok;
  logic [ADDR_BITS-1:0]   w_pc_addr;
  logic [ADDR_BITS-1:0]   w_cap_addr;
  logic [ADDR_BITS-1:0]   w_load_base;
  logic [c_DATA_BITS-1:0] w_rd_word;
  logic                   w_latch;
  logic                   w_capture;
  logic                   w_err_nxt;

  // Range check done in 64 bits so PC near 2^32 cannot wrap into range.
  assign w_pc_ok = ((PC & 32'(WORD_BYTES - 1)) == 32'd0) &&
                   ((64'(PC) + 64'(WORD_BYTES)) <= (64'd1 << ADDR_BITS));
  assign w_pc_addr   = PC[ADDR_BITS-1:0];
  assign w_load_base = LOAD_ADDR & ~c_ALIGN_MASK;

  // Next-state / control
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_latch     = 1'b0;
    w_capture   = 1'b0;
    w_err_nxt   = 1'b0;
    w_cap_addr  = r_addr;
    case (r_state)
      S_IDLE, S_DONE: begin
        // DONE is a single-cycle state unless a new request is accepted.
        w_state_nxt = S_IDLE;
        if (FETCH_REQ) begin
          if (w_pc_ok) begin
            w_latch = 1'b1;
            if (LATENCY == 1) begin
              // No WAIT phase: the word is captured on the acceptance edge.
              w_state_nxt = S_DONE;
              w_capture   = 1'b1;
              w_cap_addr  = w_pc_addr;
            end else begin
              w_state_nxt = S_WAIT;
              w_cnt_nxt   = c_CNT_LOAD;
            end
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      S_WAIT: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_state_nxt = S_DONE;
          w_capture   = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Little-endian word assembly from the byte array
  always_comb begin
    w_rd_word = '0;
    for (int b = 0; b < WORD_BYTES; b++) begin
      w_rd_word[8*b +: 8] = r_mem[w_cap_addr + ADDR_BITS'(b)];
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_instr <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
      if (w_latch) begin
        r_addr <= w_pc_addr;
      end
      if (w_capture) begin
        r_instr <= w_rd_word;
      end
    end
  end

  // Memory contents survive reset; only the load port is gated by it.
  always_ff @(posedge CLK) begin
    if (!RESET && LOAD_EN) begin
      for (int b = 0; b < WORD_BYTES; b++) begin
        r_mem[w_load_base + ADDR_BITS'(b)] <= LOAD_DATA[8*b +: 8];
      end
    end
  end

  assign INSTRUCTION = r_instr;
  assign INSTR_VALID = (r_state == S_DONE);
  assign BUSY        = (r_state == S_WAIT);
  assign FETCH_ERR   = r_err;

endmodule
`default_nettype wire
